// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default latencies.
package mdu_pkg;

    localparam int DATA_W          = 32;
    localparam int CNT_W           = 5;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit product and truncating quotient/remainder of the latched operands.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                op_signed,
    output logic [2*DATA_W-1:0] prod,
    output logic [DATA_W-1:0]   quot,
    output logic [DATA_W-1:0]   rem,
    output logic                div_zero
);

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                     input logic neg);
        return neg ? (~mag + DATA_W'(1)) : mag;
    endfunction

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic                       a_neg;
    logic                       b_neg;
    logic [DATA_W-1:0]          a_mag;
    logic [DATA_W-1:0]          b_mag;
    logic [DATA_W-1:0]          b_safe;
    logic [DATA_W-1:0]          q_mag;
    logic [DATA_W-1:0]          r_mag;

    always_comb begin
        a_neg    = op_signed & a[DATA_W-1];
        b_neg    = op_signed & b[DATA_W-1];
        a_ext    = {{DATA_W{a_neg}}, a};
        b_ext    = {{DATA_W{b_neg}}, b};
        // Product kept modulo 2^64, which is exact for both signed and unsigned 32x32.
        prod     = a_ext * b_ext;

        // Magnitude division: 0x80000000 has magnitude 0x80000000 as unsigned, so no overflow case.
        a_mag    = apply_sign(a, a_neg);
        b_mag    = apply_sign(b, b_neg);
        div_zero = (b == '0);
        b_safe   = div_zero ? DATA_W'(1) : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = apply_sign(q_mag, a_neg ^ b_neg);
        rem      = apply_sign(r_mag, a_neg);
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Optional MADD/MSUB accumulate is enabled by defining MDU_MADD_EN.
module mdu #(
    parameter int MULT_CYCLES = mdu_pkg::MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = mdu_pkg::DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import mdu_pkg::*;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      hi_q, hi_d;
    logic [DATA_W-1:0]      lo_q, lo_d;
    logic                   accept;
    mdu_op_e                op_in;

    mdu_op_e                op_p0;
    logic [DATA_W-1:0]      a_p0;
    logic [DATA_W-1:0]      b_p0;

    logic [2*DATA_W-1:0]    prod;
    logic [DATA_W-1:0]      quot;
    logic [DATA_W-1:0]      rem;
    logic                   div_zero;

    assign op_in = mdu_op_e'(mdu_op);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_in)
                        OP_MULT, OP_MULTU: begin
                            accept  = 1'b1;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            accept  = 1'b1;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MSUB: begin
                            accept  = 1'b1;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = ST_RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Retire on the edge where the counter hits zero; start is ignored throughout.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    case (op_p0)
                        OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                        OP_DIV, OP_DIVU: begin
                            if (!div_zero) begin
                                lo_d = quot;
                                hi_d = rem;
                            end
                        end
`ifdef MDU_MADD_EN
                        OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod;
                        OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stage p0: operands captured at acceptance, held for the whole run
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= op_in;
            a_p0  <= A;
            b_p0  <= B;
        end
    end

    mdu_calc u_calc (
        .a         (a_p0),
        .b         (b_p0),
        .op_signed (op_is_signed(op_p0)),
        .prod      (prod),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
